bpu_bht: RTL and testbench

BPU_BHT -- requirements
Module: bpu_bht

---
 rtl/bpu_bht.sv | 113 +++++++++++
 tb/tb_bpu_bht.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bpu_bht.sv
// Branch history table: 64-entry direct-mapped predictor with 2-bit counters,
// one-cycle registered lookup, verify-time update and mispredict redirect.
module bpu_bht #(
  parameter logic [1:0] INIT_COUNT = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [57:0] pred_entry,
  input  logic        verify_valid,
  input  logic        verify_success,
  input  logic [57:0] verify_entry,
  input  logic        verify_taken,
  input  logic [31:0] verify_target,
  input  logic [31:0] verify_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [63:0] valid_q;
  logic [57:0] table_q [64];

  logic [5:0]  v_idx;
  logic [57:0] v_stored;
  logic        v_hit;
  logic [1:0]  v_count;
  logic [1:0]  new_count;
  logic [1:0]  wr_count;
  logic        we;
  logic [57:0] wr_entry;

  logic [5:0]  f_idx;
  logic        f_valid;
  logic [57:0] f_entry;
  logic        f_hit;
  logic        f_taken;
  logic [31:0] f_target;
  logic [57:0] f_pred_entry;

  always_comb begin
    v_idx    = verify_pc[7:2];
    v_stored = table_q[v_idx];
    v_hit    = valid_q[v_idx] && (v_stored[57:36] == verify_pc[31:10]);
    v_count  = verify_entry[33:32];
    if (verify_taken)
      new_count = (v_count == 2'd3) ? 2'd3 : v_count + 2'd1;
    else
      new_count = (v_count == 2'd0) ? 2'd0 : v_count - 2'd1;
    wr_count = v_hit ? new_count : INIT_COUNT;
    we       = verify_valid && !reset && (v_hit || verify_taken);
    wr_entry = {verify_pc[31:10], verify_entry[35:34], wr_count, verify_target};
  end

  // A write landing on the looked-up index this cycle is forwarded to the lookup.
  always_comb begin
    f_idx = fetch_pc[7:2];
    if (we && (v_idx == f_idx)) begin
      f_valid = 1'b1;
      f_entry = wr_entry;
    end else begin
      f_valid = valid_q[f_idx];
      f_entry = table_q[f_idx];
    end
    f_hit = f_valid && (f_entry[57:36] == fetch_pc[31:10]);
    unique case (f_entry[35:34])
      2'b01:   f_taken = f_hit && f_entry[33];
      2'b10,
      2'b11:   f_taken = f_hit;
      default: f_taken = 1'b0;
    endcase
    f_target     = f_taken ? f_entry[31:0] : fetch_pc + 32'd8;
    f_pred_entry = f_hit ? f_entry : {fetch_pc[31:10], 2'b00, 2'b01, 32'h0};
  end

  always_ff @(posedge clk) begin
    if (we) table_q[v_idx] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[v_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid     <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      pred_entry     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      pred_valid <= fetch_valid && !flush;
      if (fetch_valid) begin
        pred_taken  <= f_taken;
        pred_target <= f_target;
        pred_entry  <= f_pred_entry;
      end
      redirect_valid <= verify_valid && !verify_success;
      if (verify_valid && !verify_success)
        redirect_pc <= verify_taken ? verify_target : verify_pc + 32'd8;
    end
  end

endmodule

// File: tb/tb_bpu_bht.sv
// Directed self-checking bench for bpu_bht with hand-computed expectations.
module tb_bpu_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [57:0] pred_entry;
  logic        verify_valid;
  logic        verify_success;
  logic [57:0] verify_entry;
  logic        verify_taken;
  logic [31:0] verify_target;
  logic [31:0] verify_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpu_bht #(.INIT_COUNT(2'b10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_entry(pred_entry),
    .verify_valid(verify_valid), .verify_success(verify_success),
    .verify_entry(verify_entry), .verify_taken(verify_taken),
    .verify_target(verify_target), .verify_pc(verify_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    verify_valid = 1'b0; verify_success = 1'b0; verify_entry = '0;
    verify_taken = 1'b0; verify_target = '0; verify_pc = '0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_verify(input logic [31:0] pc, input logic taken, input logic [1:0] btype,
                            input logic [1:0] cnt, input logic [31:0] tgt, input logic success);
    verify_valid   = 1'b1;
    verify_pc      = pc;
    verify_taken   = taken;
    verify_entry   = {pc[31:10], btype, cnt, tgt};
    verify_target  = tgt;
    verify_success = success;
  endtask

  task automatic do_verify(input logic [31:0] pc, input logic taken, input logic [1:0] btype,
                           input logic [1:0] cnt, input logic [31:0] tgt, input logic success);
    @(negedge clk);
    idle_inputs();
    set_verify(pc, taken, btype, cnt, tgt, success);
    step();
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic fl);
    @(negedge clk);
    idle_inputs();
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    flush       = fl;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 32'h1000;
    step(); step();
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_pred_entry", pred_entry, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    @(negedge clk); reset = 1'b0;

    // Cold lookup
    do_fetch(32'h1000, 1'b0);
    check("cold_valid", pred_valid, 1);
    check("cold_taken", pred_taken, 0);
    check("cold_target", pred_target, 32'h1008);
    check("cold_entry", pred_entry, {22'h4, 2'b00, 2'b01, 32'h0});
    @(negedge clk); idle_inputs(); step();
    check("no_fetch_valid", pred_valid, 0);

    // Allocate with mispredict redirect
    do_verify(32'h1000, 1'b1, 2'b01, 2'b01, 32'h2000, 1'b0);
    check("alloc_redir_valid", redirect_valid, 1);
    check("alloc_redir_pc", redirect_pc, 32'h2000);
    @(negedge clk); idle_inputs(); step();
    check("redir_one_cycle", redirect_valid, 0);
    check("redir_pc_hold", redirect_pc, 32'h2000);
    do_fetch(32'h1000, 1'b0);
    check("alloc_taken", pred_taken, 1);
    check("alloc_target", pred_target, 32'h2000);
    check("alloc_entry", pred_entry, {22'h4, 2'b01, 2'b10, 32'h2000});

    // Saturating increment
    do_verify(32'h1000, 1'b1, 2'b01, 2'b10, 32'h2000, 1'b1);
    check("succ_no_redirect", redirect_valid, 0);
    for (int i = 0; i < 3; i++) do_verify(32'h1000, 1'b1, 2'b01, 2'b11, 32'h2000, 1'b1);
    do_fetch(32'h1000, 1'b0);
    check("sat_hi_entry", pred_entry, {22'h4, 2'b01, 2'b11, 32'h2000});

    // Saturating decrement: counts captured 2,1,0,0
    do_verify(32'h1000, 1'b0, 2'b01, 2'b10, 32'h2000, 1'b1);
    do_fetch(32'h1000, 1'b0);
    check("dec1_taken", pred_taken, 0);
    do_verify(32'h1000, 1'b0, 2'b01, 2'b01, 32'h2000, 1'b1);
    do_verify(32'h1000, 1'b0, 2'b01, 2'b00, 32'h2000, 1'b1);
    do_verify(32'h1000, 1'b0, 2'b01, 2'b00, 32'h2000, 1'b1);
    do_fetch(32'h1000, 1'b0);
    check("sat_lo_taken", pred_taken, 0);
    check("sat_lo_target", pred_target, 32'h1008);
    check("sat_lo_entry", pred_entry, {22'h4, 2'b01, 2'b00, 32'h2000});

    // Alias: same index, different tag
    do_verify(32'h1000, 1'b1, 2'b01, 2'b01, 32'h2000, 1'b1);
    do_fetch(32'h1400, 1'b0);
    check("alias_taken", pred_taken, 0);
    check("alias_target", pred_target, 32'h1408);
    check("alias_entry", pred_entry, {22'h5, 2'b00, 2'b01, 32'h0});

    // Not-taken miss: redirect to pc+8 but no allocation
    do_verify(32'h3004, 1'b0, 2'b01, 2'b10, 32'h9000, 1'b0);
    check("nt_redir_valid", redirect_valid, 1);
    check("nt_redir_pc", redirect_pc, 32'h300C);
    do_fetch(32'h3004, 1'b0);
    check("nt_miss_entry", pred_entry, {22'hC, 2'b00, 2'b01, 32'h0});

    // Write-first bypass on index 0
    @(negedge clk); idle_inputs();
    set_verify(32'h2000, 1'b1, 2'b10, 2'b00, 32'h5550, 1'b1);
    fetch_valid = 1'b1; fetch_pc = 32'h2000;
    step();
    check("byp_valid", pred_valid, 1);
    check("byp_taken", pred_taken, 1);
    check("byp_target", pred_target, 32'h5550);
    check("byp_entry", pred_entry, {22'h8, 2'b10, 2'b10, 32'h5550});

    // Bypass with flush: prediction killed, write persists
    @(negedge clk); idle_inputs();
    set_verify(32'h2040, 1'b1, 2'b11, 2'b00, 32'h7000, 1'b1);
    fetch_valid = 1'b1; fetch_pc = 32'h2040; flush = 1'b1;
    step();
    check("flush_pred_valid", pred_valid, 0);
    do_fetch(32'h2040, 1'b0);
    check("flush_wr_taken", pred_taken, 1);
    check("flush_wr_target", pred_target, 32'h7000);

    // Back-to-back writes to the same index
    do_verify(32'h1000, 1'b1, 2'b01, 2'b00, 32'hA000, 1'b1);
    do_verify(32'h1000, 1'b1, 2'b01, 2'b10, 32'hB000, 1'b1);
    do_fetch(32'h1000, 1'b0);
    check("b2b_target", pred_target, 32'hB000);
    check("b2b_entry", pred_entry, {22'h4, 2'b01, 2'b11, 32'hB000});

    // Reset during an allocating mispredicted verify
    @(negedge clk); idle_inputs();
    reset = 1'b1;
    set_verify(32'h4008, 1'b1, 2'b10, 2'b00, 32'h8000, 1'b0);
    step();
    @(negedge clk); reset = 1'b0; idle_inputs();
    step();
    check("rstmid_redirect", redirect_valid, 0);
    do_fetch(32'h4008, 1'b0);
    check("rstmid_taken", pred_taken, 0);
    check("rstmid_target", pred_target, 32'h4010);
    do_fetch(32'h2040, 1'b0);
    check("rstmid_cleared", pred_taken, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
